// File: rtl/pc_fetch_unit.sv
// Purpose : fetch-stage program-counter generator. It handles reset vector,
//           boot bubble, stall, flush/trap redirect, jal/jalr/branch
//           redirects, misaligned-target fault state and an optional
//           return-address stack.
// Latency : the pc updates one cycle after the selecting inputs are sampled.
//           All outputs come from registers.
// Backpr. : stall holds the pc. flush_valid overrides stall, and it is the
//           only way out of FAULT (apart from rst).
// Options : define PC_FETCH_RAS_EN to build the RAS. Without it, ras_top and
//           ras_valid are tied to 0 and link_push/link_pop are ignored.
// Ports   : clk, rst (sync, active-high); stall; flush_valid/flush_target;
//           is_jal/jal_target; is_jalr/jalr_target;
//           branch/branch_taken/branch_target; link_push/link_pop;
//           pc/pc_valid; fault/fault_addr; ras_top/ras_valid.
module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_target,
  input  logic            is_jal,
  input  logic [XLEN-1:0] jal_target,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            link_push,
  input  logic            link_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;

  logic [XLEN-1:0] w_pc_seq;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;

  // Sequential next-pc. The addition wraps modulo 2^XLEN.
  assign w_pc_seq = r_pc + {{(XLEN-3){1'b0}}, 3'b100};

  // Redirect selection below flush/stall: jal > jalr > taken branch.
  always_comb begin
    w_redirect = 1'b0;
    w_target   = '0;
    if (is_jal) begin
      w_redirect = 1'b1;
      w_target   = jal_target;
    end else if (is_jalr) begin
      w_redirect = 1'b1;
      w_target   = {jalr_target[XLEN-1:1], 1'b0};
    end else if (branch && branch_taken) begin
      w_redirect = 1'b1;
      w_target   = branch_target;
    end
  end

  assign w_misaligned = w_redirect && (w_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VECTOR;
      r_pc_valid   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      case (r_state)
        // One-cycle warm-up bubble. The pc is held and inputs are ignored.
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (flush_valid) begin
            r_pc <= flush_target;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (w_misaligned) begin
            // The pc is frozen at the instruction that produced the bad target.
            r_fault_addr <= w_target;
            r_state      <= ST_FAULT;
            r_pc_valid   <= 1'b0;
            r_fault      <= 1'b1;
          end else if (w_redirect) begin
            r_pc <= w_target;
          end else begin
            r_pc <= w_pc_seq;
          end
        end
        ST_FAULT: begin
          if (flush_valid) begin
            r_pc       <= flush_target;
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
            r_fault    <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc_valid <= 1'b0;
          r_fault    <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

`ifdef PC_FETCH_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;            // index of the current top entry
  logic [CW-1:0]   r_cnt;            // saturating occupancy
  logic [PW-1:0]   w_ptr_inc;
  logic            w_advance;
  logic            w_ras_clear;

  assign w_ptr_inc = r_ptr + {{(PW-1){1'b0}}, 1'b1};

  // The RAS only moves on cycles where RUN actually retires a new pc.
  assign w_advance   = (r_state == ST_RUN) && !flush_valid && !stall && !w_misaligned;
  assign w_ras_clear = ((r_state != ST_BOOT) && flush_valid) ||
                       ((r_state == ST_RUN) && !stall && w_misaligned);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) r_stack[i] <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_ras_clear) begin
      r_cnt <= '0;
    end else if (w_advance) begin
      if (link_push && (!link_pop || r_cnt == '0)) begin
        // On a full stack the pointer wraps onto the oldest entry and
        // overwrites it.
        r_ptr            <= w_ptr_inc;
        r_stack[w_ptr_inc] <= w_pc_seq;
        if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else if (link_push && link_pop) begin
        r_stack[r_ptr] <= w_pc_seq;
      end else if (link_pop && r_cnt != '0) begin
        r_ptr <= r_ptr - {{(PW-1){1'b0}}, 1'b1};
        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ras_top   = r_stack[r_ptr];
  assign ras_valid = (r_cnt != '0);
`else
  logic w_unused_link;
  assign w_unused_link = link_push ^ link_pop;
  assign ras_top       = '0;
  assign ras_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose : self-checking bench for pc_fetch_unit. It runs directed
//           scenarios and then random stimulus against a queue-based
//           reference model.
// Latency : every output is checked 1 time unit after each rising edge.
// Backpr. : stall and flush are driven directly. There are no DUT-event waits.
module tb_pc_fetch_unit;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush_valid, is_jal, is_jalr, branch, branch_taken;
  logic        link_push, link_pop;
  logic [31:0] flush_target, jal_target, jalr_target, branch_target;
  logic [31:0] pc, fault_addr, ras_top;
  logic        pc_valid, fault, ras_valid;

  pc_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .flush_valid(flush_valid), .flush_target(flush_target),
    .is_jal(is_jal), .jal_target(jal_target),
    .is_jalr(is_jalr), .jalr_target(jalr_target),
    .branch(branch), .branch_taken(branch_taken), .branch_target(branch_target),
    .link_push(link_push), .link_pop(link_pop),
    .pc(pc), .pc_valid(pc_valid), .fault(fault), .fault_addr(fault_addr),
    .ras_top(ras_top), .ras_valid(ras_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. mode: 0 = boot, 1 = run, 2 = fault.
  int          m_mode;
  logic [31:0] m_pc, m_faddr;
  logic [31:0] m_ras[$];

  task automatic ras_update(input logic [31:0] ret);
`ifdef PC_FETCH_RAS_EN
    if (link_push && link_pop && m_ras.size() > 0) begin
      m_ras[m_ras.size()-1] = ret;
    end else if (link_push) begin
      m_ras.push_back(ret);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (link_pop && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
`endif
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          redir;
    if (rst) begin
      m_mode = 0; m_pc = RV; m_faddr = 0; m_ras.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (flush_valid) begin
        m_pc = flush_target; m_mode = 1; m_ras.delete();
      end
    end else if (flush_valid) begin
      m_pc = flush_target; m_ras.delete();
    end else if (!stall) begin
      redir = 1'b1;
      if (is_jal)                    tgt = jal_target;
      else if (is_jalr)              tgt = jalr_target & 32'hFFFF_FFFE;
      else if (branch && branch_taken) tgt = branch_target;
      else begin redir = 1'b0; tgt = m_pc + 32'd4; end
      if (redir && (tgt % 4) != 0) begin
        m_mode = 2; m_faddr = tgt; m_ras.delete();
      end else begin
        ras_update(m_pc + 32'd4);
        m_pc = tgt;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_top;
    check_val("pc",         pc,                 m_pc);
    check_val("pc_valid",   {31'b0, pc_valid},  {31'b0, m_mode == 1});
    check_val("fault",      {31'b0, fault},     {31'b0, m_mode == 2});
    check_val("fault_addr", fault_addr,         m_faddr);
    check_val("ras_valid",  {31'b0, ras_valid}, {31'b0, m_ras.size() > 0});
`ifdef PC_FETCH_RAS_EN
    if (m_ras.size() > 0) begin
      exp_top = m_ras[m_ras.size()-1];
      check_val("ras_top", ras_top, exp_top);
    end
`else
    exp_top = 32'h0;
    check_val("ras_top", ras_top, exp_top);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush_valid = 0; is_jal = 0; is_jalr = 0;
    branch = 0; branch_taken = 0; link_push = 0; link_pop = 0;
    flush_target = 0; jal_target = 0; jalr_target = 0; branch_target = 0;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) t = t | ($urandom() & 32'h3);
    return t;
  endfunction

  initial begin
    idle_inputs();
    // Reset and boot bubble
    rst = 1; cycle(); cycle();
    rst = 0; repeat (4) cycle();
    // Priority: jal over jalr over branch, then jalr bit-0 clear
    flush_valid = 1; flush_target = 32'h200; cycle(); idle_inputs();
    is_jal = 1; jal_target = 32'h400; is_jalr = 1; jalr_target = 32'h501;
    branch = 1; branch_taken = 1; branch_target = 32'h600; cycle(); idle_inputs();
    is_jalr = 1; jalr_target = 32'h501; cycle(); idle_inputs();
    // Stall holds, flush beats stall
    stall = 1; repeat (3) cycle();
    flush_valid = 1; flush_target = 32'h80; cycle(); idle_inputs();
    // Misaligned branch -> FAULT; jal ignored; flush exits
    branch = 1; branch_taken = 1; branch_target = 32'h302; cycle(); idle_inputs();
    is_jal = 1; jal_target = 32'h700; repeat (2) cycle(); idle_inputs();
    flush_valid = 1; flush_target = 32'h1000; cycle(); idle_inputs();
    // branch_taken without branch does nothing
    branch_taken = 1; branch_target = 32'h2000; cycle(); idle_inputs();
    // Wrap-around
    flush_valid = 1; flush_target = 32'hFFFF_FFFC; cycle(); idle_inputs();
    repeat (2) cycle();
    // RAS: five calls, then five returns
    flush_valid = 1; flush_target = 32'h10; cycle(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      link_push = 1; is_jal = 1; jal_target = 32'h10 * (i + 2); cycle();
    end
    idle_inputs();
    link_pop = 1; repeat (5) cycle(); idle_inputs();
    link_push = 1; link_pop = 1; repeat (2) cycle(); idle_inputs();
    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      flush_valid   = ($urandom_range(0, 19) == 0);
      flush_target  = $urandom() & 32'hFFFF_FFFC;
      is_jal        = ($urandom_range(0, 9) == 0);
      jal_target    = rand_target();
      is_jalr       = ($urandom_range(0, 9) == 0);
      jalr_target   = rand_target() ^ ($urandom() & 32'h1);
      branch        = ($urandom_range(0, 4) == 0);
      branch_taken  = $urandom_range(0, 1) == 1;
      branch_target = rand_target();
      link_push     = ($urandom_range(0, 3) == 0);
      link_pop      = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter generator for the fetch stage. It is the successor to the single-cycle PC register and adds:
- a configurable reset vector and width;
- stall and trap/flush redirect;
- misaligned-target fault detection with a FAULT state;
- an optional return-address stack (RAS) for predicting jalr returns.

It sits between the decode/execute redirect logic and instruction memory.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits, 4-byte aligned).
RAS_DEPTH, 4, RAS entries (power of two, >=2); used only when RAS_EN is defined.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  1  hold PC (fetch back-pressure)
flush_valid  in  1  trap/exception redirect request
flush_target  in  XLEN  trap redirect address
is_jal  in  1  jal resolved this cycle
jal_target  in  XLEN  jal destination
is_jalr  in  1  jalr resolved this cycle
jalr_target  in  XLEN  jalr destination (raw rs1+imm)
branch  in  1  conditional branch resolved
branch_taken  in  1  branch condition true
branch_target  in  XLEN  branch destination
link_push  in  1  call hint (rd is x1/x5)
link_pop  in  1  return hint (rs1 is x1/x5, rd not link)
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a fetchable address this cycle
fault  out  1  misaligned-target fault pending
fault_addr  out  XLEN  offending target
ras_top  out  XLEN  predicted return address
ras_valid  out  1  RAS non-empty

Behaviour:
- Reset:
  - pc=RESET_VECTOR, state=BOOT, pc_valid=0, fault=0, fault_addr=0.
  - RAS count=0, ras_valid=0, ras_top=0.
  - rst mid-operation overrides everything, including FAULT.
- States:
  - BOOT: pc_valid=0, pc held. Moves to RUN next cycle unconditionally (a one-cycle memory warm-up bubble).
  - RUN: pc_valid=1.
  - FAULT: pc held, pc_valid=0, fault=1.
- Next-PC priority in RUN, evaluated each cycle, highest first:
  1. flush_valid: pc<=flush_target. Flush is honoured even while stall=1.
  2. stall: pc held.
  3. is_jal: jal_target.
  4. is_jalr: {jalr_target[XLEN-1:1],1'b0}, i.e. bit 0 is cleared.
  5. branch & branch_taken: branch_target.
  6. Otherwise pc+4, wrapping modulo 2^XLEN (all-ones-minus-3 wraps to 0).
- Alignment check:
  - Applied to the selected jal, jalr or branch target only.
  - If target[1:0]!=0: pc is not updated, fault_addr<=target, state<=FAULT on the next edge.
- FAULT exit:
  - Only flush_valid (or rst) leaves FAULT: pc<=flush_target, fault<=0, state<=RUN.
  - All other inputs are ignored in FAULT.
- flush_target is not alignment-checked; the trap vector is assumed legal by construction.
- pc updates one cycle after the selecting inputs are sampled; all outputs are registered.
- Simultaneous is_jal and is_jalr: jal wins.
- branch_taken without branch has no effect.

Optional Feature:
Macro PC_FETCH_RAS_EN.

With PC_FETCH_RAS_EN defined, the RAS is a circular stack of RAS_DEPTH entries with a saturating count. Push/pop is updated only on cycles where RUN advances (not stalled, no flush, no fault):
- link_push: store pc+4 at top.
  - When full, overwrite the oldest entry; count stays RAS_DEPTH.
- link_pop: discard top if count>0. Pop on empty is ignored.
- Push and pop together: replace top with pc+4, count unchanged. If empty, behave as push only.
- flush_valid or entering FAULT clears count to 0.
- Outputs: ras_top = top entry, ras_valid = (count>0).

Without PC_FETCH_RAS_EN: no RAS storage, ras_top=0 and ras_valid=0 constantly, and link_push/link_pop are ignored.

Test Plan:
1. Reset: rst=1 for 2 cycles, RESET_VECTOR=32'h100 -> pc=0x100 with pc_valid=0 for one cycle after release, then 0x104, 0x108 with pc_valid=1.
2. Priority: at pc=0x200 drive is_jal (0x400), is_jalr (0x501) and taken branch (0x600) together -> pc=0x400. Next cycle drive is_jalr=0x501 only -> pc=0x500.
3. Stall vs flush: stall=1 for 3 cycles -> pc held at 0x500. Then stall=1 with flush_valid and flush_target=0x80 -> pc=0x80.
4. Misaligned: branch taken to 0x302 -> pc held, fault=1, fault_addr=0x302, pc_valid=0. Later jal inputs are ignored until flush_valid to 0x1000 -> pc=0x1000, fault=0.
5. Wrap: pc=0xFFFF_FFFC, no redirect -> pc=0x0000_0000.
6. RAS (PC_FETCH_RAS_EN, RAS_DEPTH=4):
   - 5 pushes at pc=0x10,0x20,0x30,0x40,0x50 -> ras_top=0x54, count=4.
   - 4 pops -> ras_valid=0, with 0x24 the last top seen (oldest entry 0x14 was overwritten).
   - A 5th pop is ignored.
